axi_rd_stream_ctrl: RTL and testbench
=====================================

# axi_rd_stream_ctrl

Command-driven AXI4 read controller that sits between a command source and the `axi_ram` read channels. It splits a byte-length read request into INCR bursts, capped by `MAX_BURST` and the 4 KB boundary, with one burst outstanding at a time. It serializes the returned 32-bit words into a byte-wide AXI-Stream with TLAST on the final requested byte.

## Interface
- DATA_WIDTH, 32, AXI read data width; only 32 is supported.
- ADDR_WIDTH, 16, AXI address width.
- ID_WIDTH, 8, ARID width; ARID is driven to constant 0.
- MAX_BURST, 16, maximum beats per burst, 1..256.
- LEN_WIDTH, 16, width of the byte-count command field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- cmd_valid / cmd_ready  in/out  1  command handshake.
- cmd_addr  in  ADDR_WIDTH  start byte address; bits [1:0] are ignored (treated as 0).
- cmd_len  in  LEN_WIDTH  byte count, must be ≥1; a value of 0 is accepted and completes immediately with no stream output.
- m_axi_arid/araddr/arlen/arsize/arburst/arvalid  out  AR channel; arsize=3'b010, arburst=2'b01.
- m_axi_arready  in  1.
- m_axi_rdata/rresp/rlast/rvalid  in  R channel; rid is ignored.
- m_axi_rready  out  1.
- m_axis_tdata  out  8; m_axis_tvalid / m_axis_tlast  out  1; m_axis_tready  in  1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky flag: some RRESP≠0 during the current command.

## Operation
- States: IDLE, ADDR, DATA, DONE.
- **IDLE**
  - cmd_ready=1.
  - On cmd handshake: latch addr (aligned), rem_bytes=cmd_len, words=ceil(len/4); clear err.
  - Go to ADDR, or to DONE if len=0.
- **ADDR**
  - arvalid=1.
  - beats = min(MAX_BURST, words remaining, (4096 − addr[11:0])/4); arlen = beats−1.
  - AR fields are stable while arvalid is high.
  - On arready: addr += 4·beats, words −= beats, go to DATA.
- **DATA**
  - Single-word holding buffer with a byte lane counter; byte 0 = rdata[7:0] (little-endian).
  - rready = !buf_valid || (tvalid && tready && current byte is the last byte used from this word).
  - Sustains 1 byte/cycle.
  - Final word: only rem_bytes mod 4 bytes are emitted (4 if the remainder is 0); the remaining lanes are dropped.
  - tlast is asserted on the byte where rem_bytes reaches 1.
  - When the rlast beat is accepted: if words>0, go to ADDR; else stay until the last byte handshakes, then go to DONE.
- **DONE**
  - done=1 for one cycle, then IDLE.
- **Errors:** any accepted beat with rresp≠0 sets err. Its data is still forwarded; the burst sequence is unchanged.
- **Reset mid-operation:** all state is discarded and no done is generated. The slave shares rst.

## Timing
- Reset values:
  - cmd_ready=0 during the rst cycle, then 1 (IDLE).
  - arvalid=0, araddr=0, arlen=0, rready=0, tvalid=0, tlast=0, tdata=0, busy=0, done=0, err=0.
- Cmd handshake at cycle N → arvalid at N+1.
- Beat accepted at cycle M → first byte tvalid at M+1.
- Last byte handshake at cycle K → done at K+1, cmd_ready at K+2.
- tvalid/tdata/tlast are held stable while tvalid && !tready.
- arvalid is never deasserted before arready.
- Simultaneous rvalid and buffer drain: the new word is loaded in the same cycle the last byte leaves, with no bubble.
- Burst turnaround: rlast accepted at cycle M → next arvalid at M+1.

## Configuration
- `ARS_STATS_EN` defined: adds outputs stat_bursts[15:0] (count of AR handshakes) and stat_stall[15:0] (cycles with tvalid && !tready).
  - Both are saturating and cleared only by rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- RAM word i = {4i+3, 4i+2, 4i+1, 4i}; cmd addr 0x0000, len 24, tready=1 → one AR with arlen=5; bytes 0x00..0x17 on consecutive cycles; tlast on 0x17; done one cycle later.
- len 6 at 0x0000 → arlen=1; bytes 00..05; bytes 06/07 dropped; tlast on 05.
- addr 0x0FF8, len 32 → AR 0x0FF8 arlen=1, then AR 0x1000 arlen=5; 32 contiguous bytes.
- len 100, MAX_BURST=16 → arlen 15 then 8; tlast on byte 100 only.
- Random tready toggling (50%) on the len 100 command → byte sequence unchanged; no tdata change while stalled.
- Beat 2 returned with rresp=2'b10 → err=1 through done; cleared on the next cmd accept.
- rst asserted mid-DATA → all outputs reach reset values next cycle; a following command completes correctly.

Source files
------------

// File: rtl/axi_rd_stream_ctrl.sv
// AXI4 read controller: splits byte-length commands into INCR bursts (MAX_BURST / 4 KB capped)
// and serializes 32-bit read data into a byte stream. Define ARS_STATS_EN for burst/stall counters.
module axi_rd_stream_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
`ifdef ARS_STATS_EN
  output logic [15:0]           stat_bursts,
  output logic [15:0]           stat_stall,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // state   | meaning
  // IDLE    | waiting for a command, cmd_ready high
  // ADDR    | presenting the next burst on AR
  // DATA    | accepting beats of the current burst / draining the final word
  // DONE    | one-cycle completion pulse
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

  localparam int CW = (LEN_WIDTH > 11) ? LEN_WIDTH : 11;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic [LEN_WIDTH-1:0]  rem_bytes_q, rem_bytes_d;
  logic                  err_q, err_d;
  logic                  rd_done_q, rd_done_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [1:0]            lane_q, lane_d;

  logic [CW-1:0] bnd_words, max_words, words_ext, beats;
  logic          byte_hs, beat_hs, word_end;

  // Burst size: smallest of the burst cap, the words still owed and the room left in this 4 KB page.
  always_comb begin
    bnd_words = CW'(11'd1024 - {1'b0, addr_q[11:2]});
    max_words = CW'(MAX_BURST);
    words_ext = CW'(words_q);
    beats     = max_words;
    if (words_ext < beats) beats = words_ext;
    if (bnd_words < beats) beats = bnd_words;
  end

  assign word_end = (lane_q == 2'd3) || (rem_bytes_q == LEN_WIDTH'(1));
  assign byte_hs  = buf_valid_q && m_axis_tready;
  assign beat_hs  = m_axi_rvalid && m_axi_rready;

  assign cmd_ready     = (state_q == ST_IDLE) && !rst;
  assign m_axi_arvalid = (state_q == ST_ADDR);
  assign m_axi_araddr  = m_axi_arvalid ? addr_q : '0;
  assign m_axi_arlen   = m_axi_arvalid ? 8'(beats - CW'(1)) : 8'd0;
  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  // A new beat may land in the same cycle the last used byte of the held word leaves.
  assign m_axi_rready  = (state_q == ST_DATA) && !rd_done_q &&
                         (!buf_valid_q || (byte_hs && word_end));
  assign m_axis_tvalid = buf_valid_q;
  assign m_axis_tdata  = buf_valid_q ? buf_q[{lane_q, 3'b000} +: 8] : 8'd0;
  assign m_axis_tlast  = buf_valid_q && (rem_bytes_q == LEN_WIDTH'(1));
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    words_d     = words_q;
    rem_bytes_d = rem_bytes_q;
    err_d       = err_q;
    rd_done_d   = rd_done_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    lane_d      = lane_q;

    if (byte_hs) begin
      rem_bytes_d = rem_bytes_q - LEN_WIDTH'(1);
      if (word_end) buf_valid_d = 1'b0;
      else          lane_d      = lane_q + 2'd1;
    end
    if (beat_hs) begin
      buf_d       = m_axi_rdata;
      buf_valid_d = 1'b1;
      lane_d      = 2'd0;
      if (m_axi_rresp != 2'b00) err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr & ~ADDR_WIDTH'(3);
          rem_bytes_d = cmd_len;
          words_d     = LEN_WIDTH'(({1'b0, cmd_len} + (LEN_WIDTH+1)'(3)) >> 2);
          err_d       = 1'b0;
          rd_done_d   = 1'b0;
          state_d     = (cmd_len == '0) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi_arready) begin
          addr_d  = addr_q + ADDR_WIDTH'({beats, 2'b00});
          words_d = words_q - LEN_WIDTH'(beats);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_hs && m_axi_rlast) begin
          if (words_q != '0) state_d   = ST_ADDR;
          else               rd_done_d = 1'b1;
        end
        if (rd_done_q && byte_hs && m_axis_tlast) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      words_q     <= '0;
      rem_bytes_q <= '0;
      err_q       <= 1'b0;
      rd_done_q   <= 1'b0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      lane_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      rem_bytes_q <= rem_bytes_d;
      err_q       <= err_d;
      rd_done_q   <= rd_done_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      lane_q      <= lane_d;
    end
  end

`ifdef ARS_STATS_EN
  logic [15:0] stat_bursts_q, stat_bursts_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_bursts_d = stat_bursts_q;
    stat_stall_d  = stat_stall_q;
    if (m_axi_arvalid && m_axi_arready && (stat_bursts_q != 16'hffff))
      stat_bursts_d = stat_bursts_q + 16'd1;
    if (m_axis_tvalid && !m_axis_tready && (stat_stall_q != 16'hffff))
      stat_stall_d = stat_stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bursts_q <= 16'd0;
      stat_stall_q  <= 16'd0;
    end else begin
      stat_bursts_q <= stat_bursts_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_bursts = stat_bursts_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_axi_rd_stream_ctrl.sv
// Bench for axi_rd_stream_ctrl: reactive AXI RAM slave plus a byte/burst-list model checked each cycle.
module tb_axi_rd_stream_ctrl;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready;
  logic [15:0] cmd_addr, cmd_len;
  logic [7:0]  m_axi_arid, m_axi_arlen;
  logic [15:0] m_axi_araddr;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst, m_axi_rresp;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        busy, done, err;
`ifdef ARS_STATS_EN
  logic [15:0] stat_bursts, stat_stall;
`endif

  axi_rd_stream_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
`ifdef ARS_STATS_EN
    .stat_bursts(stat_bursts), .stat_stall(stat_stall),
`endif
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  // requests from the test sequence, applied at the next falling edge
  logic        req_rst = 1'b1, req_valid = 1'b0;
  logic [15:0] req_addr = '0, req_len = '0;
  logic        rand_tready = 1'b0;
  int          ar_lat = 0, ar_wait = 0, err_beat = -1, cmd_beat = 0;
  // slave burst state
  logic [15:0] s_addr = '0;
  int          s_left = 0;
  // model
  logic [7:0]  exp_bytes[$];
  int          exp_ar_addr[$], exp_ar_len[$];
  logic        idle_exp = 1'b1, err_exp = 1'b0, done_next = 1'b0, done_exp, post_rst = 1'b0;
  logic        p_cmd_nz = 0, p_beat = 0, p_turn = 0, p_tstall = 0, p_arstall = 0;
  logic [7:0]  p_tdata, p_arlen;
  logic        p_tlast;
  logic [15:0] p_araddr;
  // per-command observations
  int          obs_n, obs_addr[8], obs_len[8], n_bytes, n_tlast, first_cyc, last_cyc;
  logic [7:0]  last_tlast_data;
  logic        saw_done;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic build_model(input logic [15:0] addr, input logic [15:0] len);
    int a, w, b;
    a = int'(addr) & 'hFFFC;
    for (int j = 0; j < int'(len); j++) exp_bytes.push_back(8'((a + j) & 'hFF));
    w = (int'(len) + 3) / 4;
    while (w > 0) begin
      b = MAXB;
      if (w < b) b = w;
      if ((4096 - (a % 4096)) / 4 < b) b = (4096 - (a % 4096)) / 4;
      exp_ar_addr.push_back(a & 'hFFFF);
      exp_ar_len.push_back(b - 1);
      a += 4 * b;
      w -= b;
    end
  endtask

  task automatic sample();
    if (rst) begin
      chk("cmd_ready_in_rst", cmd_ready, 0);
      exp_bytes.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
      s_left = 0; ar_wait = 0; idle_exp = 1; err_exp = 0; done_next = 0; post_rst = 1;
      p_cmd_nz = 0; p_beat = 0; p_turn = 0; p_tstall = 0; p_arstall = 0;
      return;
    end
    done_exp = done_next;
    done_next = 0;
    if (post_rst) begin
      chk("rst_arvalid", m_axi_arvalid, 0); chk("rst_araddr", m_axi_araddr, 0);
      chk("rst_arlen", m_axi_arlen, 0);     chk("rst_rready", m_axi_rready, 0);
      chk("rst_tvalid", m_axis_tvalid, 0);  chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      post_rst = 0;
    end
    chk("busy", busy, int'(!idle_exp));
    chk("cmd_ready", cmd_ready, int'(idle_exp));
    chk("done", done, int'(done_exp));
    chk("err", err, int'(err_exp));
    if (done) saw_done = 1;
    if (p_cmd_nz) chk("arvalid_after_cmd", m_axi_arvalid, 1);
    if (p_beat)   chk("tvalid_after_beat", m_axis_tvalid, 1);
    if (p_turn)   chk("arvalid_after_rlast", m_axi_arvalid, 1);
    if (p_tstall) begin
      chk("stall_tvalid", m_axis_tvalid, 1);
      chk("stall_tdata", m_axis_tdata, p_tdata);
      chk("stall_tlast", m_axis_tlast, p_tlast);
    end
    if (p_arstall) begin
      chk("ar_hold_valid", m_axi_arvalid, 1);
      chk("ar_hold_addr", m_axi_araddr, p_araddr);
      chk("ar_hold_len", m_axi_arlen, p_arlen);
    end
    p_cmd_nz = 0; p_beat = 0; p_turn = 0;

    if (cmd_valid && cmd_ready) begin
      build_model(cmd_addr, cmd_len);
      idle_exp = 0; err_exp = 0; cmd_beat = 0; req_valid = 0;
      if (cmd_len == 0) done_next = 1; else p_cmd_nz = 1;
    end
    if (m_axi_arvalid && m_axi_arready) begin
      chk("ar_expected", int'(exp_ar_addr.size() > 0), 1);
      if (exp_ar_addr.size() > 0) begin
        chk("araddr", m_axi_araddr, exp_ar_addr.pop_front());
        chk("arlen", m_axi_arlen, exp_ar_len.pop_front());
        chk("ar_fixed", {m_axi_arid, m_axi_arsize, m_axi_arburst}, {8'd0, 3'b010, 2'b01});
      end
      if (obs_n < 8) begin obs_addr[obs_n] = m_axi_araddr; obs_len[obs_n] = m_axi_arlen; end
      obs_n++;
      s_addr = m_axi_araddr; s_left = int'(m_axi_arlen) + 1; ar_wait = 0;
    end else if (m_axi_arvalid) ar_wait++;
    if (m_axi_rvalid && m_axi_rready) begin
      if (m_axi_rresp != 2'b00) err_exp = 1;
      p_beat = 1;
      if (m_axi_rlast && exp_ar_addr.size() > 0) p_turn = 1;
      cmd_beat++; s_addr += 16'd4; s_left--;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      chk("byte_expected", int'(exp_bytes.size() > 0), 1);
      if (exp_bytes.size() > 0) begin
        chk("tdata", m_axis_tdata, exp_bytes[0]);
        chk("tlast", m_axis_tlast, int'(exp_bytes.size() == 1));
        if (exp_bytes.size() == 1) done_next = 1;
        void'(exp_bytes.pop_front());
      end
      if (n_bytes == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_bytes++;
      if (m_axis_tlast) begin n_tlast++; last_tlast_data = m_axis_tdata; end
    end
    p_tstall = m_axis_tvalid && !m_axis_tready;
    p_tdata = m_axis_tdata; p_tlast = m_axis_tlast;
    p_arstall = m_axi_arvalid && !m_axi_arready;
    p_araddr = m_axi_araddr; p_arlen = m_axi_arlen;
    if (done_exp) idle_exp = 1;
  endtask

  task automatic tick();
    logic [7:0] b0;
    @(negedge clk);
    rst = req_rst;
    cmd_valid = req_valid; cmd_addr = req_addr; cmd_len = req_len;
    m_axi_arready = (ar_wait >= ar_lat);
    b0 = s_addr[7:0];
    m_axi_rvalid = (s_left > 0);
    m_axi_rdata  = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    m_axi_rlast  = (s_left == 1);
    m_axi_rresp  = (cmd_beat == err_beat) ? 2'b10 : 2'b00;
    m_axis_tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    sample();
    cyc++;
  endtask

  task automatic run_cmd(input logic [15:0] addr, input logic [15:0] len);
    obs_n = 0; n_bytes = 0; n_tlast = 0; first_cyc = 0; last_cyc = 0;
    last_tlast_data = 8'h00; saw_done = 0;
    req_addr = addr; req_len = len; req_valid = 1;
    for (int i = 0; i < 600 && !saw_done; i++) tick();
    chk("done_seen", int'(saw_done), 1);
    req_valid = 0;
    tick();
  endtask

  initial begin
    rst = 1; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0; m_axi_rresp = '0;
    m_axis_tready = 1;
    tick(); tick();
    req_rst = 0;
    tick();

    run_cmd(16'h0000, 16'd24);
    chk("t1_bursts", obs_n, 1);
    chk("t1_addr", obs_addr[0], 'h0000);
    chk("t1_arlen", obs_len[0], 5);
    chk("t1_bytes", n_bytes, 24);
    chk("t1_tlast_byte", last_tlast_data, 'h17);
    chk("t1_tlast_count", n_tlast, 1);
    chk("t1_back_to_back", last_cyc - first_cyc, 23);

    run_cmd(16'h0000, 16'd6);
    chk("t2_arlen", obs_len[0], 1);
    chk("t2_bytes", n_bytes, 6);
    chk("t2_tlast_byte", last_tlast_data, 'h05);

    ar_lat = 2;
    run_cmd(16'h0FF8, 16'd32);
    ar_lat = 0;
    chk("t3_bursts", obs_n, 2);
    chk("t3_addr0", obs_addr[0], 'h0FF8);
    chk("t3_len0", obs_len[0], 1);
    chk("t3_addr1", obs_addr[1], 'h1000);
    chk("t3_len1", obs_len[1], 5);
    chk("t3_bytes", n_bytes, 32);
    chk("t3_tlast_byte", last_tlast_data, 'h17);

    run_cmd(16'h0000, 16'd100);
    chk("t4_bursts", obs_n, 2);
    chk("t4_len0", obs_len[0], 15);
    chk("t4_len1", obs_len[1], 8);
    chk("t4_tlast_byte", last_tlast_data, 'h63);
    chk("t4_tlast_count", n_tlast, 1);

    rand_tready = 1;
    run_cmd(16'h0000, 16'd100);
    rand_tready = 0;
    chk("t5_bytes", n_bytes, 100);
    chk("t5_tlast_byte", last_tlast_data, 'h63);

    err_beat = 2;
    run_cmd(16'h0040, 16'd24);
    err_beat = -1;
    chk("t6_err_sticky", err, 1);
    run_cmd(16'h0000, 16'd8);
    chk("t6_err_cleared", err, 0);

    run_cmd(16'h0100, 16'd0);
    chk("t7_zero_bytes", n_bytes, 0);
    chk("t7_zero_bursts", obs_n, 0);

    req_addr = 16'h0000; req_len = 16'd100; req_valid = 1;
    for (int i = 0; i < 20; i++) tick();
    req_valid = 0;
    req_rst = 1; tick();
    req_rst = 0; tick();
    tick();
    run_cmd(16'h0000, 16'd24);
    chk("t8_bytes", n_bytes, 24);
    chk("t8_tlast_byte", last_tlast_data, 'h17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
